// File: rtl/ctrl_unit_pkg.sv
// Shared opcode, register-index and FSM state definitions for the ctrl_unit slice.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_ADDI = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ACC_IDX  = 4'd0;
  localparam logic [3:0] ZERO_IDX = 4'd15;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_READ,
    ST_EXEC,
    ST_HALT
  } state_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// Instruction-ROM and register-file bus between ctrl_unit (master) and its environment (slave).
interface ctrl_unit_if #(parameter int unsigned PC_W = 8);
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic            we_reg;
  logic [3:0]      addr_reg;
  logic [7:0]      data_reg;
  logic [7:0]      out_reg;
  logic [7:0]      acc;
  logic            flag_z;
  logic            flag_c;
  logic            halted;
  logic            illegal;

  modport master (
    output imem_addr, we_reg, addr_reg, data_reg, flag_z, flag_c, halted, illegal,
    input  imem_data, out_reg, acc
  );

  modport slave (
    input  imem_addr, we_reg, addr_reg, data_reg, flag_z, flag_c, halted, illegal,
    output imem_data, out_reg, acc
  );
endinterface

// File: rtl/ctrl_unit_alu8.sv
// 8-bit combinational ALU; carry passes through unchanged for logic ops.
module alu8
  import ctrl_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  input  logic       c_in,
  output logic [7:0] res,
  output logic       c_out,
  output logic       z
);

  logic [8:0] wide;

  // Bit 8 of the 9-bit subtract is the borrow, set exactly when a < b.
  always_comb begin
    wide = {c_in, a};
    case (op)
      OP_ADD, OP_ADDI: wide = {1'b0, a} + {1'b0, b};
      OP_SUB:          wide = {1'b0, a} - {1'b0, b};
      OP_AND:          wide = {c_in, a & b};
      OP_OR:           wide = {c_in, a | b};
      OP_XOR:          wide = {c_in, a ^ b};
      default:         wide = {c_in, a};
    endcase
  end

  assign res   = wide[7:0];
  assign c_out = wide[8];
  assign z     = (wide[7:0] == '0);

endmodule

// File: rtl/ctrl_unit.sv
// Four-cycle fetch/decode/read/exec controller for the 8-bit accumulator datapath.
// Optional macro CTRL_SINGLE_STEP_EN adds a step input that gates leaving FETCH.
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned PC_W            = 8,
  parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic         step,
`endif
  ctrl_unit_if.master  bus
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [7:0]      operand;
  logic            z_q;
  logic            c_q;

  logic [3:0] opcode;
  logic [3:0] r;
  logic [7:0] imm;
  logic [7:0] alu_b;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_z;
  logic       alu_op;
  logic       writes;
  logic       branch;
  logic       illegal_op;
  logic [3:0] dest;
  logic [7:0] wdata;

  assign opcode = ir[15:12];
  assign r      = ir[11:8];
  assign imm    = ir[7:0];

  assign alu_op     = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI};
  assign writes     = alu_op || (opcode inside {OP_LDI, OP_MOV, OP_STA});
  assign illegal_op = is_illegal(opcode);
  assign branch     = (opcode == OP_JMP) || ((opcode == OP_JZ) && z_q) ||
                      ((opcode == OP_JC) && c_q);
  assign dest       = (opcode == OP_LDI || opcode == OP_STA) ? r : ACC_IDX;
  assign alu_b      = (opcode == OP_ADDI) ? imm : operand;

  alu8 u_alu (
    .a    (bus.acc),
    .b    (alu_b),
    .op   (opcode),
    .c_in (c_q),
    .res  (alu_res),
    .c_out(alu_c),
    .z    (alu_z)
  );

  always_comb begin
    case (opcode)
      OP_LDI:  wdata = imm;
      OP_MOV:  wdata = operand;
      OP_STA:  wdata = bus.acc;
      default: wdata = alu_res;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc      <= '0;
      ir      <= '0;
      operand <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
`ifdef CTRL_SINGLE_STEP_EN
          if (step) state <= ST_DECODE;
`else
          state <= ST_DECODE;
`endif
        end
        ST_DECODE: begin
          ir    <= bus.imem_data;
          pc    <= pc + PC_W'(1);
          state <= ST_READ;
        end
        ST_READ: begin
          operand <= (r == ZERO_IDX) ? '0 : bus.out_reg;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (alu_op) begin
            z_q <= alu_z;
            c_q <= alu_c;
          end
          // A taken jump overrides the increment already applied in DECODE.
          if (branch) pc <= PC_W'(imm);
          if (opcode == OP_HALT || (illegal_op && HALT_ON_ILLEGAL))
            state <= ST_HALT;
          else
            state <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.we_reg   = 1'b0;
    bus.addr_reg = '0;
    bus.data_reg = '0;
    bus.illegal  = 1'b0;
    case (state)
      ST_READ: bus.addr_reg = r;
      ST_EXEC: begin
        bus.addr_reg = dest;
        bus.we_reg   = writes && (dest != ZERO_IDX);
        bus.data_reg = wdata;
        bus.illegal  = illegal_op;
      end
      default: ;
    endcase
  end

  assign bus.imem_addr = pc;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;
  assign bus.halted    = (state == ST_HALT);

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: an ISA-level interpreter predicts fetches, EXEC bus activity and flags.
`timescale 1ns/1ps
module tb_ctrl_unit;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  always #5 clk = ~clk;

  ctrl_unit_if #(.PC_W(8)) bus();

  ctrl_unit #(.PC_W(8), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .bus (bus)
  );

  logic [15:0] rom     [256];
  logic [7:0]  rf      [16];
  logic [7:0]  rf_init [16];
  logic        load_rf = 1'b1;

  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  always @(posedge clk) begin
    if (load_rf) begin
      for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
    end else if (bus.we_reg) begin
      rf[bus.addr_reg] <= bus.data_reg;
    end
  end

  assign bus.out_reg = rf[bus.addr_reg];
  assign bus.acc     = rf[0];

  typedef struct {
    bit         we;
    logic [3:0] rd;
    logic [3:0] addr;
    logic [7:0] data;
    bit         ill;
  } exec_t;

  exec_t      eq[$];
  logic [7:0] pcq[$];
  logic [1:0] fq[$];
  logic [7:0] mregs[16];
  bit         exp_halt;
  logic [7:0] exp_pc_final;
  bit         active = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] r, input logic [7:0] imm);
    return {op, r, imm};
  endfunction

  // Instruction-level interpreter: one loop iteration per architectural instruction.
  task automatic model(input int n);
    logic [7:0] pc, opv, a, wd, imm;
    logic [3:0] op, r, wa;
    logic [15:0] w;
    bit z, c, hlt, wr;
    int sum;
    exec_t e;
    pc = 8'd0; z = 1'b0; c = 1'b0; hlt = 1'b0;
    pcq.delete(); eq.delete(); fq.delete();
    for (int i = 0; i < 16; i++) mregs[i] = rf_init[i];
    for (int i = 0; i < n && !hlt; i++) begin
      w = rom[pc]; op = w[15:12]; r = w[11:8]; imm = w[7:0];
      pcq.push_back(pc);
      pc  = pc + 8'd1;
      opv = (r == 4'd15) ? 8'd0 : mregs[r];
      a   = mregs[0];
      e   = '{we: 1'b0, rd: r, addr: 4'd0, data: 8'd0, ill: 1'b0};
      wr = 1'b0; wa = 4'd0; wd = 8'd0;
      case (op)
        4'h1: begin wr = 1'b1; wa = r; wd = imm; end
        4'h2: begin wr = 1'b1; wa = 4'd0; wd = opv; end
        4'h3: begin wr = 1'b1; wa = r; wd = a; end
        4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC: begin
          case (op)
            4'h4: begin sum = int'(a) + int'(opv); c = (sum > 255); end
            4'h5: begin sum = int'(a) - int'(opv); c = (a < opv); end
            4'h6: sum = int'(a & opv);
            4'h7: sum = int'(a | opv);
            4'h8: sum = int'(a ^ opv);
            default: begin sum = int'(a) + int'(imm); c = (sum > 255); end
          endcase
          wd = 8'(sum & 255);
          z  = (wd == 8'd0);
          wr = 1'b1; wa = 4'd0;
        end
        4'h9: pc = imm;
        4'hA: if (z) pc = imm;
        4'hB: if (c) pc = imm;
        4'hD, 4'hE: begin e.ill = 1'b1; hlt = 1'b1; end
        4'hF: hlt = 1'b1;
        default: ;
      endcase
      if (wr && wa != 4'd15) begin
        e.we = 1'b1; e.addr = wa; e.data = wd;
        mregs[wa] = wd;
      end
      eq.push_back(e);
      fq.push_back({z, c});
    end
    exp_halt     = hlt;
    exp_pc_final = pc;
  endtask

  // Monitor: cycle phase since reset release identifies which output is presented.
  exec_t      me;
  logic [1:0] mf;
  logic [7:0] mp;
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0;
    end else if (active) begin
      case (cyc % 4)
        0: begin
          chk("we_fetch", bus.we_reg, 0);
          if (pcq.size() > 0) begin
            mp = pcq.pop_front();
            chk("fetch_pc", bus.imem_addr, mp);
            chk("halted_low", bus.halted, 0);
          end else begin
            chk("halted", bus.halted, exp_halt);
            if (exp_halt) chk("frozen_pc", bus.imem_addr, exp_pc_final);
          end
        end
        1: begin
          chk("addr_idle", bus.addr_reg, 0);
          if (cyc >= 4 && fq.size() > 0) begin
            mf = fq.pop_front();
            chk("flag_z", bus.flag_z, mf[1]);
            chk("flag_c", bus.flag_c, mf[0]);
          end
        end
        2: begin
          chk("we_read", bus.we_reg, 0);
          if (eq.size() > 0) chk("read_addr", bus.addr_reg, eq[0].rd);
          else chk("addr_halt", bus.addr_reg, 0);
        end
        default: begin
          if (eq.size() > 0) begin
            me = eq.pop_front();
            chk("exec_we", bus.we_reg, me.we);
            chk("exec_illegal", bus.illegal, me.ill);
            if (me.we) begin
              chk("exec_addr", bus.addr_reg, me.addr);
              chk("exec_data", bus.data_reg, me.data);
            end
          end else begin
            chk("we_halt", bus.we_reg, 0);
            chk("illegal_halt", bus.illegal, 0);
          end
        end
      endcase
      cyc++;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 16; i++) rf_init[i] = 8'($urandom);
  endtask

  task automatic rand_prog();
    int k;
    logic [3:0] op;
    for (int i = 0; i < 256; i++) begin
      k = $urandom_range(0, 99);
      if (k == 0)      op = 4'hF;
      else if (k == 1) op = 4'hD;
      else if (k == 2) op = 4'hE;
      else             op = 4'($urandom_range(0, 12));
      rom[i] = ins(op, 4'($urandom_range(0, 15)), 8'($urandom));
    end
    for (int i = 0; i < 16; i++) rf_init[i] = 8'($urandom);
  endtask

  task automatic run_prog(input int n);
    rst = 1'b1; load_rf = 1'b1; active = 1'b0;
    model(n);
    repeat (2) @(posedge clk);
    #2 load_rf = 1'b0; rst = 1'b0; active = 1'b1;
    repeat (4 * n) @(posedge clk);
    #1;
    while (fq.size() > 0) begin
      mf = fq.pop_front();
      chk("final_flag_z", bus.flag_z, mf[1]);
      chk("final_flag_c", bus.flag_c, mf[0]);
    end
    chk("queues_drained", pcq.size() + eq.size(), 0);
    for (int i = 0; i < 16; i++) chk("regfile", rf[i], mregs[i]);
    active = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_we", bus.we_reg, 0);
    chk("reset_addr", bus.addr_reg, 0);
    chk("reset_pc", bus.imem_addr, 0);
    chk("reset_flags", {bus.flag_z, bus.flag_c, bus.halted, bus.illegal}, 0);

    clear_rom();
    rom[0] = ins(OP_LDI, 4'd1, 8'h05); rom[1] = ins(OP_LDI, 4'd0, 8'hFF);
    rom[2] = ins(OP_ADD, 4'd1, 8'h00);
    run_prog(3);
    chk("add_acc", rf[0], 8'h04); chk("add_r1", rf[1], 8'h05);
    chk("add_c", bus.flag_c, 1);  chk("add_z", bus.flag_z, 0);

    clear_rom();
    rom[0] = ins(OP_LDI, 4'd0, 8'h03); rom[1] = ins(OP_LDI, 4'd2, 8'h03);
    rom[2] = ins(OP_SUB, 4'd2, 8'h00); rom[3] = ins(OP_JZ, 4'd0, 8'h40);
    run_prog(5);
    chk("sub_eq_acc", rf[0], 8'h00); chk("sub_eq_z", bus.flag_z, 1); chk("sub_eq_c", bus.flag_c, 0);

    clear_rom();
    rom[0] = ins(OP_LDI, 4'd0, 8'h03); rom[1] = ins(OP_LDI, 4'd2, 8'h05);
    rom[2] = ins(OP_SUB, 4'd2, 8'h00); rom[3] = ins(OP_JC, 4'd0, 8'h10);
    rom[8'h10] = ins(OP_JZ, 4'd0, 8'h30);
    run_prog(6);
    chk("sub_lt_acc", rf[0], 8'hFE); chk("sub_lt_c", bus.flag_c, 1);

    clear_rom();
    rom[0] = ins(OP_LDI, 4'd15, 8'hAA); rom[1] = ins(OP_MOV, 4'd15, 8'h00);
    run_prog(2);
    chk("mov_zero_acc", rf[0], 8'h00);

    clear_rom();
    rom[0] = ins(OP_JMP, 4'd0, 8'hFF);
    run_prog(3);

    clear_rom();
    rom[0] = ins(OP_LDI, 4'd4, 8'h12); rom[1] = 16'hD000;
    rom[2] = ins(OP_LDI, 4'd5, 8'h01);
    run_prog(5);
    chk("illegal_halted", bus.halted, 1);

    for (int p = 0; p < 6; p++) begin
      rand_prog();
      run_prog(30);
    end

    // Reset during EXEC of LDI r3,0x77 must abort the write.
    clear_rom();
    rom[0] = ins(OP_LDI, 4'd3, 8'h77);
    rf_init[3] = 8'h11;
    rst = 1'b1; load_rf = 1'b1;
    repeat (2) @(posedge clk);
    #2 load_rf = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("abort_we_pre", bus.we_reg, 1);
    chk("abort_addr_pre", bus.addr_reg, 3);
    rst = 1'b1;
    #1;
    chk("abort_we_drop", bus.we_reg, 0);
    chk("abort_pc", bus.imem_addr, 0);
    @(posedge clk);
    #1;
    chk("abort_r3_kept", rf[3], 8'h11);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("restart_exec_we", bus.we_reg, 1);
    chk("restart_exec_data", bus.data_reg, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
- Multi-cycle fetch/decode/execute controller for the 8-bit accumulator datapath. It sits directly upstream of the register file and drives its write-enable, address and write-data.
- It fetches 16-bit instructions from a synchronous instruction ROM and reads operands through the register file's single shared address port.
- It contains the ALU and the Z/C flags.
- Fixed 4 cycles per instruction; no pipelining.

Parameters:
- PC_W, 8, program counter / instruction ROM address width.
- HALT_ON_ILLEGAL, 0, when 1 an undefined opcode enters HALT; when 0 it executes as NOP.

Ports:
- clk  in  1  clock
- rst  in  1  reset (see Behaviour)
- imem_addr  out  PC_W  instruction ROM address (= pc)
- imem_data  in  16  ROM data, valid one cycle after imem_addr
- we_reg  out  1  register file write enable
- addr_reg  out  4  register file address (read and write)
- data_reg  out  8  register file write data
- out_reg  in  8  register file read data, combinational on addr_reg
- acc  in  8  accumulator (register 0) contents
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag
- halted  out  1  high while in HALT
- illegal  out  1  one-cycle pulse in EXEC for an undefined opcode

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: state=FETCH, pc=0, ir=0, operand=0, flag_z=0, flag_c=0; outputs we_reg=0, addr_reg=0, data_reg=0, halted=0, illegal=0. Reset mid-instruction aborts it; no write occurs.
- Instruction format: ir[15:12]=opcode, ir[11:8]=r, ir[7:0]=imm.
- Opcodes:
  - 0 NOP
  - 1 LDI: r<=imm
  - 2 MOV: ACC<=r
  - 3 STA: r<=ACC
  - 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR: ACC<=ACC op r
  - 9 JMP: pc<=imm
  - A JZ: branch if Z
  - B JC: branch if C
  - C ADDI: ACC<=ACC+imm
  - F HALT
  - D, E undefined
- FSM states: FETCH -> DECODE -> READ -> EXEC -> FETCH; plus HALT (absorbing until reset).
- FETCH: imem_addr=pc.
- DECODE: ir<=imem_data at the cycle end; pc<=pc+1, wrapping 0xFF->0x00.
- READ: addr_reg=r; operand<=out_reg at the cycle end. If r==15, operand<=0 regardless of out_reg.
- EXEC: addr_reg=destination (r for LDI/STA, 0 for ALU ops and MOV). we_reg=1 for LDI/MOV/STA/ALU/ADDI, except when the destination is 15; that write is suppressed (we_reg=0). Jumps load pc from imm, overriding the DECODE increment.
- Outputs are combinational from registered state/ir/operand. we_reg is 0 outside EXEC. addr_reg is 0 in FETCH/DECODE/HALT.
- ALU arithmetic is 9-bit:
  - ADD/ADDI: {C,res}=acc+op.
  - SUB: res=acc-op; C=1 iff acc<op (borrow).
  - AND/OR/XOR: C unchanged.
  - Z=(res==0) for all ALU ops, updated at the EXEC clock edge.
  - LDI/MOV/STA/jumps leave flags unchanged.
- Flag timing: JZ/JC test the flags committed by the previous instruction.
- Undefined opcode: illegal=1 in EXEC. Then HALT if HALT_ON_ILLEGAL=1, else continue as NOP.
- HALT opcode: enters HALT after its EXEC; halted=1; pc frozen.

Optional Feature:
- Macro CTRL_SINGLE_STEP_EN.
- When defined: extra input port step (1 bit). The FSM stays in FETCH until step==1, then proceeds through one full instruction. step is sampled only in FETCH.
- When undefined: port is absent and FETCH always advances.

Decomposition:
- Package ctrl_pkg: opcode localparams (OP_NOP..OP_HALT), state encoding typedef, register indices ACC_IDX=0 and ZERO_IDX=15.
- Sub-module alu8 (combinational): inputs a, b, op, c_in; outputs res[7:0], c_out, z. Instantiated once.

Test Plan:
- Reset then release; ROM: LDI r1,0x05; LDI r0,0xFF; ADD r1 -> writes observed: r1=0x05, r0=0xFF, then r0=0x04 with C=1, Z=0. Instruction start cycles 0/4/8.
- ACC=0x03, SUB r2 with r2=0x03 -> ACC=0x00, Z=1, C=0. Then JZ 0x40 -> imem_addr=0x40 in next FETCH.
- ACC=0x03, SUB r2 with r2=0x05 -> ACC=0xFE, C=1. Then JC 0x10 taken; JZ not taken (pc=prev+1).
- LDI r15,0xAA -> we_reg stays 0 in EXEC. MOV r15 -> ACC=0x00.
- pc=0xFF executing NOP -> next imem_addr=0x00. Opcode 0xD with HALT_ON_ILLEGAL=1 -> illegal pulses once, halted=1, no further writes.
- Assert rst during EXEC of LDI r3,0x77 -> we_reg drops immediately; r3 not written; pc=0; FSM restarts in FETCH.
